// File: rtl/div_pkg.sv
// div_pkg: shared state type and constants for the shared-divider arbiter
package div_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int W_DEFAULT = 8;
    localparam logic [63:0] DZ_QUOTIENT = '1;
endpackage

// File: rtl/div_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr with wrap
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);
    int j;
    // scan offsets high to low so the smallest offset from ptr wins
    always_comb begin
        grant = '0;
        j = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            j = (j >= N) ? j - N : j;
            grant = req[j] ? (N'(1) << j) : grant;
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider among N requesters
module div_arbiter
    import div_pkg::*;
#(
    parameter int N = 4,
    parameter int W = W_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_dividend,
    input  logic [N*W-1:0] req_divisor,
    output logic [N-1:0]   resp_valid,
    output logic [W-1:0]   resp_q,
    output logic [W-1:0]   resp_rem,
    output logic           resp_dz,
    output logic [W-1:0]   div_dividend,
    output logic [W-1:0]   div_divisor,
    output logic           div_i_valid,
    input  logic           div_busy,
    input  logic [W-1:0]   div_q,
    input  logic [W-1:0]   div_rem,
    input  logic           div_o_valid,
    output logic           err_timeout,
    output logic           err_stray
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] gidx;
    logic [N-1:0]  grant;
    logic [CW-1:0] cnt;
    logic [W-1:0]  g_dividend;
    logic [W-1:0]  g_divisor;

    rr_arbiter #(.N(N)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready   = (state == IDLE && !rst) ? grant : '0;
    assign div_i_valid = state == ISSUE && !div_busy && !div_o_valid && !rst;
    assign resp_valid  = (state == RESP) ? (N'(1) << owner) : '0;

    // index and operands of the granted requester
    always_comb begin
        gidx = '0;
        g_dividend = '0;
        g_divisor = '0;
        for (int i = 0; i < N; i++) begin
            gidx = grant[i] ? PW'(i) : gidx;
            g_dividend = grant[i] ? req_dividend[i*W +: W] : g_dividend;
            g_divisor = grant[i] ? req_divisor[i*W +: W] : g_divisor;
        end
    end

    // FSM: accept, issue to divider, wait with timeout, pulse response to owner
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            cnt          <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            resp_q       <= '0;
            resp_rem     <= '0;
            resp_dz      <= 1'b0;
            err_timeout  <= 1'b0;
            err_stray    <= 1'b0;
        end else begin
            if (div_o_valid && state != WAIT) err_stray <= 1'b1;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner        <= gidx;
                        ptr          <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
                        div_dividend <= g_dividend;
                        div_divisor  <= g_divisor;
                        cnt          <= '0;
                        if (g_divisor == '0) begin
                            resp_q   <= DZ_QUOTIENT[W-1:0];
                            resp_rem <= g_dividend;
                            resp_dz  <= 1'b1;
                            state    <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= div_i_valid ? WAIT : ISSUE;
                WAIT: begin
                    if (div_o_valid) begin
                        resp_q   <= div_q;
                        resp_rem <= div_rem;
                        resp_dz  <= 1'b0;
                        state    <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Shares one iterative divider (ports clk, rst, dividend, divisor, i_valid, busy, q, rem, o_valid) between N requesters. The block arbitrates requests round-robin and issues one division at a time. Each result returns to the requester that issued it. Divide-by-zero is handled locally and never reaches the divider, because the divider requires divisor > 0.

Parameters:
N, 4, number of requesters (2..8)
W, 8, operand/result width
TIMEOUT, 64, max cycles from issue to div_o_valid before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N  per-requester request
req_ready  out  N  one-hot grant/accept; handshake when req_valid[i] & req_ready[i]
req_dividend  in  N*W  packed dividends, requester i at [i*W +: W]
req_divisor  in  N*W  packed divisors
resp_valid  out  N  one-hot, one-cycle result pulse to owner
resp_q  out  W  quotient
resp_rem  out  W  remainder
resp_dz  out  1  result was divide-by-zero
div_dividend  out  W  to divider dividend
div_divisor  out  W  to divider divisor
div_i_valid  out  1  to divider i_valid
div_busy  in  1  from divider busy
div_q  in  W  from divider q
div_rem  in  W  from divider rem
div_o_valid  in  1  from divider o_valid
err_timeout  out  1  sticky: divider failed to answer within TIMEOUT
err_stray  out  1  sticky: div_o_valid seen while not in WAIT

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - all outputs 0
  - state IDLE
  - round-robin pointer 0, so requester 0 has highest priority first
  - timeout counter 0
- Reset mid-operation: the in-flight request is dropped with no response. A later div_o_valid from that operation sets err_stray.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i], searching from the pointer upward with wrap.
  - req_ready is combinational from req_valid and state, asserted in IDLE only: req_ready[g]=1, all other bits 0.
  - On grant, capture operands and owner=g. Pointer becomes g+1 mod N.
  - If divisor==0: set resp_q=all ones, resp_rem=dividend, resp_dz=1, then go to RESP.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_i_valid=1 only when !div_busy & !div_o_valid & !rst. This meets the divider contract: no i_valid with busy, o_valid or rst.
  - The cycle div_i_valid=1 is the issue cycle; next state WAIT. Otherwise hold in ISSUE with div_i_valid=0.
  - div_dividend and div_divisor hold the captured operands from ISSUE through WAIT.
- WAIT:
  - Counter increments each cycle.
  - On div_o_valid: latch div_q/div_rem into resp_q/resp_rem, resp_dz=0, go to RESP.
  - If the counter reaches TIMEOUT first: set err_timeout, go to IDLE, no response.
- RESP: resp_valid[owner]=1 for exactly one cycle, then IDLE. resp_q/resp_rem/resp_dz hold until the next RESP.
- Latency:
  - Normal: accept at T, issue at T+1 (no stall), o_valid at X, resp_valid at X+1, next grant possible at X+2.
  - Divide-by-zero: accept at T, resp_valid at T+1.
- One request in flight at most. Requests arriving during ISSUE/WAIT/RESP wait; req_valid must hold until accepted.
- Simultaneous requests are served in pointer order; no requester waits more than N grants.
- A div_o_valid outside WAIT sets err_stray and is otherwise ignored.
- Operand widths pass through unchanged; no arithmetic in the block except the counter and pointer increment.

Decomposition:
- Shared package div_pkg: state enum (IDLE, ISSUE, WAIT, RESP), DZ_QUOTIENT constant (all ones), default W.
- One natural sub-module, rr_arbiter (N-bit request vector plus pointer in, one-hot grant out). It is combinational and reusable.
- FSM, capture registers and timeout counter live in div_arbiter.

Test Plan:
- Single request: req0 asks 100/7 -> req_ready[0] same cycle, div_i_valid next cycle, then resp_valid[0] with q=14, rem=2, resp_dz=0.
- Contention: req0..3 all valid at once with 8/2, 9/3, 10/5, 13/4 -> served in order 0,1,2,3. Responses are 4r0, 3r0, 2r0, 3r1, each to its own resp_valid bit.
- Fairness after wrap: after requester 2 is served, requesters 0 and 3 both valid -> 3 granted before 0.
- Divide-by-zero: req1 asks 55/0 -> resp_valid[1] one cycle after accept with q=255, rem=55, resp_dz=1, and div_i_valid never asserted.
- Stall and timeout:
  - div_busy held high in ISSUE -> div_i_valid stays 0 until busy drops.
  - div_o_valid withheld for TIMEOUT cycles -> err_timeout=1, no resp_valid, next request accepted.
- Reset mid-WAIT: rst for one cycle -> all outputs 0, pointer 0. A late div_o_valid afterwards sets err_stray=1 and produces no response.
